maxpool_relu: RTL
=================

MAXPOOL_RELU -- requirements
Module: maxpool_relu

Interface
REQ-001 Parameter in_width, default 3, columns of the incoming conv result map.
REQ-002 Parameter in_height, default 3, rows of the incoming conv result map.
REQ-003 Parameter data_width, default 6, width of one signed element (conv output width 2*expand*bitwidth).
REQ-004 Parameter pool_size, default 2, square pooling window edge.
REQ-005 Parameter pool_stride, default 1, window step in both directions.
REQ-006 Derived out_width = (in_width-pool_size)/pool_stride+1; out_height likewise from in_height.
REQ-007 clk_en  input  1  sole clock, rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 pool_en  input  1  start request, sampled high in IDLE (driven by conv_fin upstream).
REQ-010 feature  input  in_width*in_height*data_width  conv result map; element (r,c) at bits [(r*in_width+c)*data_width +: data_width].
REQ-011 result  output  out_width*out_height*data_width  pooled map, same packing rule with out_width.
REQ-012 pool_fin  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high in SCAN.

Function
REQ-014 States IDLE and SCAN only; IDLE->SCAN on rising edge with pool_en=1; SCAN->IDLE on the edge processing the last element of the last window.
REQ-015 On the IDLE->SCAN edge, feature shall be captured into an internal buffer; later feature changes shall not affect the run.
REQ-016 SCAN shall process exactly one window element per cycle, order: window row-major (orow, ocol), element row-major (ky, kx) within a window.
REQ-017 Element addressed = buffer (orow*pool_stride+ky, ocol*pool_stride+kx).
REQ-018 Running max shall be loaded with the window's first element and updated with signed two's-complement compare on subsequent elements.
REQ-019 On a window's last element, result slot (orow,ocol) shall receive ReLU(max): 0 if max negative, else max; width data_width, no saturation.
REQ-020 pool_fin shall go high for exactly one cycle, registered on the same edge that writes the last slot; latency from start edge = out_width*out_height*pool_size^2 edges.
REQ-021 result shall hold its value from pool_fin until the next run overwrites slots; unwritten slots keep old values during a run.
REQ-022 pool_en while busy shall be ignored (no restart, no queueing).
REQ-023 pool_en held high across pool_fin shall start a new run on the first IDLE edge.
REQ-024 pool_size=1 shall yield ReLU pass-through of subsampled elements.

Reset
REQ-025 rst_n=0 at an edge shall force IDLE, result=0, pool_fin=0, busy=0, counters and running max=0, regardless of state.
REQ-026 Reset mid-SCAN shall abort the run with no pool_fin pulse; next run requires a fresh pool_en.

Structure
REQ-027 Shared package (cnn_pkg) holds the state encoding and the out_width/out_height derivation function, shared with conv_top.
REQ-028 One sub-module, pool_addr_gen: nested counters (ocol, orow, kx, ky) producing element index, first/last-of-window and last-of-run flags.
REQ-029 Max compare, ReLU and result write stay in maxpool_relu.

Verification
REQ-030 Default params, feature rows {4,9,7},{10,2,9},{13,12,4}, pool_en 1 cycle -> pool_fin exactly 16 edges later, result rows {10,9},{13,12}.
REQ-031 Window all negative (-5 = 6'b111011, -1, -3, -2) -> slot = 0; mixed {-5,3,-1,0} -> slot = 3.
REQ-032 rst_n low at SCAN cycle 7 -> no pool_fin, result=0, busy=0 next cycle; restart gives REQ-030 values.
REQ-033 pool_en pulsed at SCAN cycle 5 and feature changed mid-run -> single pool_fin at 16, values from original capture.
REQ-034 pool_en held high 40 cycles -> pool_fin at edges 16 and 33, busy low exactly one cycle between runs.
REQ-035 pool_stride=2, in 4x4 ramp 0..15 -> 2x2 result {5,7},{13,15}, pool_fin 16 edges after start.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and geometry helpers for the CNN pipeline blocks
package cnn_pkg;
    typedef enum logic {IDLE, SCAN} pool_state_t;

    function automatic int out_dim(input int in_dim, input int pool, input int stride);
        return (in_dim - pool) / stride + 1;
    endfunction

    function automatic int bits(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: walks windows row-major and elements row-major within each window
module pool_addr_gen import cnn_pkg::*; #(
    parameter int in_width = 3,
    parameter int in_height = 3,
    parameter int pool_size = 2,
    parameter int pool_stride = 1,
    localparam int out_w = out_dim(in_width, pool_size, pool_stride),
    localparam int out_h = out_dim(in_height, pool_size, pool_stride),
    localparam int idx_bits = bits(in_width * in_height),
    localparam int slot_bits = bits(out_w * out_h),
    localparam int cnt_bits = bits(in_width > in_height ? in_width : in_height)
) (
    input  logic                 clk_en,
    input  logic                 rst_n,
    input  logic                 step,
    output logic [idx_bits-1:0]  idx,
    output logic [slot_bits-1:0] slot,
    output logic                 first,
    output logic                 last,
    output logic                 last_run
);
    logic [cnt_bits-1:0] kx, ky, ocol, orow;
    logic kx_end, ky_end, ocol_end, orow_end;

    always_comb begin
        kx_end = kx == cnt_bits'(pool_size - 1);
        ky_end = ky == cnt_bits'(pool_size - 1);
        ocol_end = ocol == cnt_bits'(out_w - 1);
        orow_end = orow == cnt_bits'(out_h - 1);
        first = kx == '0 && ky == '0;
        last = kx_end && ky_end;
        last_run = last && ocol_end && orow_end;
        idx = idx_bits'((int'(orow) * pool_stride + int'(ky)) * in_width + int'(ocol) * pool_stride + int'(kx));
        slot = slot_bits'(int'(orow) * out_w + int'(ocol));
    end

    // every counter wraps to zero after the last element, so a new run needs no clear
    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            kx <= '0;
            ky <= '0;
            ocol <= '0;
            orow <= '0;
        end else if (step) begin
            kx <= kx_end ? '0 : kx + 1'b1;
            if (kx_end) ky <= ky_end ? '0 : ky + 1'b1;
            if (last) ocol <= ocol_end ? '0 : ocol + 1'b1;
            if (last && ocol_end) orow <= orow_end ? '0 : orow + 1'b1;
        end
    end
endmodule

// File: rtl/maxpool_relu.sv
// maxpool_relu: sequential max pooling with ReLU over a captured conv result map
module maxpool_relu import cnn_pkg::*; #(
    parameter int in_width = 3,
    parameter int in_height = 3,
    parameter int data_width = 6,
    parameter int pool_size = 2,
    parameter int pool_stride = 1,
    localparam int out_width = out_dim(in_width, pool_size, pool_stride),
    localparam int out_height = out_dim(in_height, pool_size, pool_stride),
    localparam int idx_bits = bits(in_width * in_height),
    localparam int slot_bits = bits(out_width * out_height)
) (
    input  logic                                         clk_en,
    input  logic                                         rst_n,
    input  logic                                         pool_en,
    input  logic [in_width*in_height*data_width-1:0]     feature,
    output logic [out_width*out_height*data_width-1:0]   result,
    output logic                                         pool_fin,
    output logic                                         busy
);
    pool_state_t state;
    logic [in_width*in_height*data_width-1:0] fbuf;
    logic signed [data_width-1:0] run_max, elem, cur_max;
    logic [idx_bits-1:0] idx;
    logic [slot_bits-1:0] slot;
    logic first, last, last_run;

    pool_addr_gen #(
        .in_width(in_width),
        .in_height(in_height),
        .pool_size(pool_size),
        .pool_stride(pool_stride)
    ) u_addr (
        .clk_en(clk_en),
        .rst_n(rst_n),
        .step(state == SCAN),
        .idx(idx),
        .slot(slot),
        .first(first),
        .last(last),
        .last_run(last_run)
    );

    always_comb begin
        elem = fbuf[int'(idx)*data_width +: data_width];
        cur_max = (first || elem > run_max) ? elem : run_max;
    end

    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            state <= IDLE;
            result <= '0;
            run_max <= '0;
            pool_fin <= 1'b0;
            busy <= 1'b0;
        end else begin
            pool_fin <= 1'b0;
            if (state == IDLE) begin
                if (pool_en) begin
                    fbuf <= feature;
                    state <= SCAN;
                    busy <= 1'b1;
                end
            end else begin
                run_max <= cur_max;
                if (last) result[int'(slot)*data_width +: data_width] <= cur_max[data_width-1] ? '0 : cur_max;
                if (last_run) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    pool_fin <= 1'b1;
                end
            end
        end
    end
endmodule
